// File: rtl/computer_pkg.sv
// -----------------------------------------------------------------------------
// computer_pkg
// Shared definitions for the 16-bit accumulator microcomputer: address/data
// widths, opcodes, interrupt vectors, CPU and UART receiver state encodings,
// the decoded instruction layout and the ALU helper.
// -----------------------------------------------------------------------------
package computer_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_IN   = 4'hA;
    localparam logic [3:0] OP_EIDI = 4'hB;
    localparam logic [3:0] OP_RETI = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [ADDR_W-1:0] VEC_TRAP = 8'h04;
    localparam logic [ADDR_W-1:0] VEC_INTR = 8'h08;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2
    } cpu_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Bits [11:8] of the instruction word carry no meaning, so they are not kept.
    typedef struct packed {
        logic [3:0]        op;
        logic [ADDR_W-1:0] a;
    } instr_t;

    // Arithmetic/logic ops on the accumulator; wraps modulo 2^16, no flags.
    function automatic logic [DATA_W-1:0] alu_result(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] opnd
    );
        case (op)
            OP_ADD:  alu_result = acc + opnd;
            OP_SUB:  alu_result = acc - opnd;
            OP_AND:  alu_result = acc & opnd;
            OP_OR:   alu_result = acc | opnd;
            default: alu_result = acc;
        endcase
    endfunction

endpackage

// File: rtl/computer_ram.sv
// -----------------------------------------------------------------------------
// computer_ram
// Single-port word RAM with synchronous read (one clock latency) and one
// write port. Contents are not touched by reset; the program image is placed
// in "memory" by the surrounding environment.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   async active-low reset (read register only)
//   addr_i   in   word address
//   we_i     in   write enable
//   wdata_i  in   write data
//   rdata_o  out  registered read data of the previous cycle's address
// -----------------------------------------------------------------------------
module computer_ram
    import computer_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] memory [0:MEM_WORDS-1];
    logic [DATA_W-1:0] rdata_q;

    // Write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            memory[addr_i] <= wdata_i;
        end
    end

    // Synchronous read register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= 16'h0000;
        end else begin
            rdata_q <= memory[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// -----------------------------------------------------------------------------
// uart_rx_8n1
// 8N1 UART receiver, LSB first, idle high. A start is detected on a falling
// edge of the synchronised line and confirmed at mid start bit; data and stop
// bits are sampled at mid-bit. Frames with a low stop bit are discarded.
// Ports:
//   clk_i   in   clock, rising edge
//   rst_ni  in   async active-low reset
//   rx_i    in   serial input
//   byte_o  out  last good received byte
//   done_o  out  one-clock pulse when byte_o has just been updated
// -----------------------------------------------------------------------------
module uart_rx_8n1
    import computer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       done_o
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic             fall_s;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             done_q, done_d;

    // Only a clean high-to-low transition can start a frame, so an undefined
    // or stuck line never launches reception by level alone.
    assign fall_s = rx_prev_q & ~rx_sync_q;

    // Input synchroniser plus edge-detect history; idle level is high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RX_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            byte_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: bit timing, sampling and frame acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        done_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (fall_s) begin
                    state_d = RX_START;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d = {CNT_W{1'b0}};
                    bit_d = 3'd0;
                    // Line back high at mid start bit: glitch, not a frame.
                    if (!rx_sync_q) begin
                        state_d = RX_DATA;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = {CNT_W{1'b0}};
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    state_d = RX_DATA;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_END) begin
                    state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        done_d = 1'b0;
                    end
                end else begin
                    state_d = RX_STOP;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o = byte_q;
    assign done_o = done_q;

endmodule

// File: rtl/computer.sv
// -----------------------------------------------------------------------------
// computer_top
// 16-bit multi-cycle accumulator microcomputer: CPU (inline), word RAM
// (instance "ram"), 8N1 UART receiver, edge-latched interrupt and trap.
// Every instruction takes FETCH -> DECODE -> EXEC; taking a vector adds one
// FETCH cycle. There are no outputs: state is observed through ram.memory.
// Ports:
//   clock_50_b7a  in  system clock, rising edge
//   reset         in  asynchronous active-low reset
//   uart_rx       in  UART serial input, idle high
//   intr          in  interrupt request, rising edge latched
//   trap          in  fault request, rising edge latched, beats intr
// -----------------------------------------------------------------------------
module computer_top
    import computer_pkg::*;
#(
    parameter int MEM_WORDS    = 256,
    parameter int CLKS_PER_BIT = 16
) (
    input logic clock_50_b7a,
    input logic reset,
    input logic uart_rx,
    input logic intr,
    input logic trap
);

    cpu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    instr_t            ir_q, ir_d;
    logic              ie_q, ie_d;
    logic              intr_pend_q, intr_pend_d;
    logic              trap_pend_q, trap_pend_d;
    logic              intr_smp_q, trap_smp_q;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;

    logic              intr_rise_s, trap_rise_s, service_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic              ram_we_s;
    logic [DATA_W-1:0] ram_rdata_s;
    logic [7:0]        rx_byte_s, in_byte_s;
    logic              rx_done_s;

    computer_ram #(
        .MEM_WORDS (MEM_WORDS)
    ) ram (
        .clk_i   (clock_50_b7a),
        .rst_ni  (reset),
        .addr_i  (ram_addr_s),
        .we_i    (ram_we_s),
        .wdata_i (acc_q),
        .rdata_o (ram_rdata_s)
    );

    uart_rx_8n1 #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk_i  (clock_50_b7a),
        .rst_ni (reset),
        .rx_i   (uart_rx),
        .byte_o (rx_byte_s),
        .done_o (rx_done_s)
    );

    assign intr_rise_s = intr & ~intr_smp_q;
    assign trap_rise_s = trap & ~trap_smp_q;
    // Anything that must redirect the CPU at the next instruction boundary.
    assign service_s   = trap_pend_q | (intr_pend_q & ie_q);
    // A byte finishing in the same cycle as IN is returned directly.
    assign in_byte_s   = rx_done_s ? rx_byte_s : rx_data_q;

    // CPU architectural state, pending flags and request sampling flops.
    always_ff @(posedge clock_50_b7a or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= 8'h00;
            epc_q       <= 8'h00;
            acc_q       <= 16'h0000;
            ir_q.op     <= 4'h0;
            ir_q.a      <= 8'h00;
            ie_q        <= 1'b0;
            intr_pend_q <= 1'b0;
            trap_pend_q <= 1'b0;
            intr_smp_q  <= 1'b0;
            trap_smp_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            epc_q       <= epc_d;
            acc_q       <= acc_d;
            ir_q        <= ir_d;
            ie_q        <= ie_d;
            intr_pend_q <= intr_pend_d;
            trap_pend_q <= trap_pend_d;
            intr_smp_q  <= intr;
            trap_smp_q  <= trap;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    // CPU next-state logic, RAM port control and instruction execution.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        epc_d       = epc_q;
        acc_d       = acc_q;
        ir_d        = ir_q;
        ie_d        = ie_q;
        // A fresh edge always wins over a clear in the same cycle.
        intr_pend_d = intr_pend_q | intr_rise_s;
        trap_pend_d = trap_pend_q | trap_rise_s;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        ram_addr_s  = pc_q;
        ram_we_s    = 1'b0;

        if (rx_done_s) begin
            rx_data_d  = rx_byte_s;
            rx_valid_d = 1'b1;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        case (state_q)
            ST_FETCH: begin
                ram_addr_s = pc_q;
                if (trap_pend_q) begin
                    epc_d       = pc_q;
                    pc_d        = VEC_TRAP;
                    ie_d        = 1'b0;
                    trap_pend_d = trap_rise_s;
                end else if (intr_pend_q && ie_q) begin
                    epc_d       = pc_q;
                    pc_d        = VEC_INTR;
                    ie_d        = 1'b0;
                    intr_pend_d = intr_rise_s;
                end else begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ir_d.op    = ram_rdata_s[15:12];
                ir_d.a     = ram_rdata_s[7:0];
                pc_d       = pc_q + 8'd1;
                // Operand read is issued now so it is available in EXEC.
                ram_addr_s = ram_rdata_s[7:0];
                state_d    = ST_EXEC;
            end
            ST_EXEC: begin
                ram_addr_s = ir_q.a;
                state_d    = ST_FETCH;
                case (ir_q.op)
                    OP_NOP:  acc_d = acc_q;
                    OP_LDI:  acc_d = {8'h00, ir_q.a};
                    OP_LD:   acc_d = ram_rdata_s;
                    OP_ST:   ram_we_s = 1'b1;
                    OP_ADD, OP_SUB, OP_AND, OP_OR:
                             acc_d = alu_result(ir_q.op, acc_q, ram_rdata_s);
                    OP_JMP:  pc_d = ir_q.a;
                    OP_JZ: begin
                        if (acc_q == 16'h0000) begin
                            pc_d = ir_q.a;
                        end else begin
                            pc_d = pc_q;
                        end
                    end
                    OP_IN: begin
                        acc_d      = {8'h00, in_byte_s};
                        rx_valid_d = rx_done_s;
                    end
                    OP_EIDI: ie_d = ir_q.a[0];
                    OP_RETI: begin
                        pc_d = epc_q;
                        ie_d = 1'b1;
                    end
                    OP_HALT: begin
                        if (service_s) begin
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end
                    default: acc_d = acc_q;
                endcase
            end
            default: state_d = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_computer_top.sv
module tb_computer_top;
    import computer_pkg::*;

    logic clock   = 1'b0;
    logic reset   = 1'b0;
    logic uart_rx = 1'b1;
    logic intr    = 1'b0;
    logic trap    = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    computer_top #(
        .MEM_WORDS    (256),
        .CLKS_PER_BIT (16)
    ) U0 (
        .clock_50_b7a (clock),
        .reset        (reset),
        .uart_rx      (uart_rx),
        .intr         (intr),
        .trap         (trap)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic begin_load();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            U0.ram.memory[i] <= 16'h0000;
        end
    endtask

    task automatic put(input logic [7:0] a, input logic [15:0] w);
        U0.ram.memory[a] <= w;
    endtask

    task automatic end_load();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        #160;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            #160;
        end
        uart_rx = stop;
        #160;
        uart_rx = 1'b1;
        #160;
    endtask

    function automatic logic [31:0] mem(input logic [7:0] a);
        return 32'(U0.ram.memory[a]);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  lat;
        bit  got;

        // ---------------- reset state ----------------
        @(negedge clock);
        check_eq("rst_pc",    32'(U0.pc_q), 32'h0);
        check_eq("rst_acc",   32'(U0.acc_q), 32'h0);
        check_eq("rst_state", 32'(U0.state_q), 32'(ST_FETCH));
        check_eq("rst_ie",    32'(U0.ie_q), 32'h0);
        check_eq("rst_rxv",   32'(U0.rx_valid_q), 32'h0);

        // ---------------- 1: ALU ----------------
        begin_load();
        put(8'd0, 16'h1A05);  // LDI 5 (bits 11:8 ignored)
        put(8'd1, 16'h3020);  // ST 32
        put(8'd2, 16'h4020);  // ADD 32 -> 10
        put(8'd3, 16'h3022);  // ST 34
        put(8'd4, 16'h5020);  // SUB 32 -> 5
        put(8'd5, 16'h3024);  // ST 36
        put(8'd6, 16'h100C);  // LDI 12
        put(8'd7, 16'h7020);  // OR 32 -> 0x0D
        put(8'd8, 16'h3026);  // ST 38
        put(8'd9, 16'h100E);  // LDI 14
        put(8'd10, 16'h6020); // AND 32 -> 0x04
        put(8'd11, 16'h3028); // ST 40
        put(8'd12, 16'h1000); // LDI 0
        put(8'd13, 16'h5020); // SUB 32 -> 0xFFFB
        put(8'd14, 16'h302A); // ST 42
        put(8'd15, 16'h2022); // LD 34 -> 0x000A
        put(8'd16, 16'hF000); // HALT
        end_load();
        run(80);
        check_eq("alu_m32", mem(8'd32), 32'h0005);
        check_eq("alu_m34", mem(8'd34), 32'h000A);
        check_eq("alu_m36", mem(8'd36), 32'h0005);
        check_eq("alu_or",  mem(8'd38), 32'h000D);
        check_eq("alu_and", mem(8'd40), 32'h0004);
        check_eq("alu_wrap", mem(8'd42), 32'hFFFB);
        check_eq("alu_ld_acc", 32'(U0.acc_q), 32'h000A);
        check_eq("halt_pc", 32'(U0.pc_q), 32'h11);
        check_eq("halt_state", 32'(U0.state_q), 32'(ST_EXEC));

        // ---------------- 2: branches ----------------
        begin_load();
        put(8'd0, 16'h1000);  // LDI 0
        put(8'd1, 16'h9006);  // JZ 6 (taken)
        put(8'd4, 16'h1001);  // LDI 1 (skipped)
        put(8'd6, 16'h3020);  // ST 32
        put(8'd7, 16'h1003);  // LDI 3
        put(8'd8, 16'hD0FF);  // opcode D behaves as NOP
        put(8'd9, 16'h900C);  // JZ 12 (not taken)
        put(8'd10, 16'h3021); // ST 33
        put(8'd11, 16'h800B); // JMP 11
        put(8'd12, 16'h3022); // ST 34 (never reached)
        put(8'd32, 16'hDEAD);
        put(8'd34, 16'hBEEF);
        end_load();
        run(60);
        check_eq("jz_taken_m32", mem(8'd32), 32'h0000);
        check_eq("jz_not_m33",   mem(8'd33), 32'h0003);
        check_eq("jz_not_m34",   mem(8'd34), 32'hBEEF);
        check_eq("jmp_loop_pc",  32'(U0.pc_q == 8'd11 || U0.pc_q == 8'd12), 32'h1);

        // ---------------- 3: interrupt ----------------
        begin_load();
        put(8'd0, 16'hB001);  // EI
        put(8'd1, 16'h8001);  // JMP 1
        put(8'd8, 16'h2028);  // LD 40
        put(8'd9, 16'h4029);  // ADD 41
        put(8'd10, 16'h3028); // ST 40 (entry counter)
        put(8'd11, 16'h1007); // LDI 7
        put(8'd12, 16'h3021); // ST 33
        put(8'd13, 16'hC000); // RETI
        put(8'd41, 16'h0001);
        end_load();
        run(20);
        intr = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clock);
            lat++;
            if (lat == 2) intr = 1'b0;
            if (U0.pc_q == 8'h08) got = 1'b1;
        end
        intr = 1'b0;
        check_eq("irq_vector_seen", 32'(got), 32'h1);
        check_eq("irq_latency_le4", 32'(lat <= 4), 32'h1);
        check_eq("irq_ie_cleared", 32'(U0.ie_q), 32'h0);
        run(40);
        check_eq("irq_m33", mem(8'd33), 32'h0007);
        check_eq("irq_single_entry", mem(8'd40), 32'h0001);
        check_eq("irq_epc", 32'(U0.epc_q), 32'h01);
        check_eq("irq_ie_restored", 32'(U0.ie_q), 32'h1);
        check_eq("irq_pend_clear", 32'(U0.intr_pend_q), 32'h0);
        check_eq("irq_back_in_loop", 32'(U0.pc_q == 8'd1 || U0.pc_q == 8'd2), 32'h1);

        // ---------------- 4: trap priority ----------------
        begin_load();
        put(8'd0, 16'hB001);  // EI
        put(8'd1, 16'h8001);  // JMP 1
        put(8'd4, 16'h1001);  // trap: LDI 1
        put(8'd5, 16'h3022);  //       ST 34
        put(8'd6, 16'hC000);  //       RETI
        put(8'd8, 16'h2022);  // intr: LD 34
        put(8'd9, 16'h4029);  //       ADD 41
        put(8'd10, 16'h3023); //       ST 35
        put(8'd11, 16'hC000); //       RETI
        put(8'd41, 16'h0001);
        end_load();
        run(20);
        intr = 1'b1;
        trap = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clock);
            lat++;
            intr = 1'b0;
            trap = 1'b0;
            if (U0.pc_q == 8'h04 || U0.pc_q == 8'h08) got = 1'b1;
        end
        check_eq("trap_first_vector", 32'(U0.pc_q), 32'h04);
        run(60);
        check_eq("trap_m34", mem(8'd34), 32'h0001);
        check_eq("trap_then_intr_m35", mem(8'd35), 32'h0002);
        check_eq("trap_pends_clear", 32'({U0.trap_pend_q, U0.intr_pend_q}), 32'h0);

        // ---------------- 5: UART ----------------
        begin_load();
        put(8'd0, 16'hB001);  // EI
        put(8'd1, 16'hF000);  // HALT
        put(8'd2, 16'hF000);  // HALT
        put(8'd8, 16'hA000);  // IN
        put(8'd9, 16'h3020);  // ST 32
        put(8'd10, 16'hC000); // RETI
        end_load();
        run(10);
        send_byte(8'h55, 1'b1);
        run(2);
        check_eq("uart_valid", 32'(U0.rx_valid_q), 32'h1);
        check_eq("uart_data", 32'(U0.rx_data_q), 32'h55);
        intr = 1'b1;
        run(1);
        intr = 1'b0;
        run(30);
        check_eq("uart_in_m32", mem(8'd32), 32'h0055);
        check_eq("uart_in_clears_valid", 32'(U0.rx_valid_q), 32'h0);
        check_eq("uart_halt_pc", 32'(U0.pc_q), 32'h03);
        send_byte(8'hA3, 1'b0);
        run(20);
        check_eq("uart_badstop_valid", 32'(U0.rx_valid_q), 32'h0);
        check_eq("uart_badstop_data", 32'(U0.rx_data_q), 32'h55);
        send_byte(8'h3C, 1'b1);
        run(2);
        check_eq("uart_second_valid", 32'(U0.rx_valid_q), 32'h1);
        check_eq("uart_second_data", 32'(U0.rx_data_q), 32'h3C);

        // ---------------- 6: reset mid-instruction ----------------
        begin_load();
        put(8'd0, 16'h1009);  // LDI 9
        put(8'd1, 16'h3020);  // ST 32
        put(8'd2, 16'hF000);  // HALT
        put(8'd32, 16'hDEAD);
        end_load();
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clock);
            lat++;
            if (U0.state_q == ST_DECODE && U0.pc_q == 8'd1) got = 1'b1;
        end
        check_eq("rst_mid_reached", 32'(got), 32'h1);
        reset = 1'b0;
        #1;
        check_eq("rst_mid_pc", 32'(U0.pc_q), 32'h0);
        check_eq("rst_mid_acc", 32'(U0.acc_q), 32'h0);
        check_eq("rst_mid_state", 32'(U0.state_q), 32'(ST_FETCH));
        run(2);
        check_eq("rst_mid_no_write", mem(8'd32), 32'hDEAD);
        reset = 1'b1;
        run(20);
        check_eq("rst_rerun_write", mem(8'd32), 32'h0009);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
